// File: rtl/graphics_pkg.sv
// Screen geometry, float constants and projection FSM states shared by the graphics pipeline.
package graphics_pkg;

  localparam int SCREEN_W     = 1280;
  localparam int SCREEN_H     = 720;
  localparam int HALF_W       = 640;
  localparam int HALF_H       = 360;
  localparam int DRAIN_CYCLES = 32;

  localparam logic [31:0] ONE_F   = 32'h3f800000;
  localparam logic [31:0] SCALE_F = 32'h43b40000;
  localparam logic [31:0] NEAR_F  = 32'h3dcccccd;

  typedef enum logic [3:0] {
    StDrain, StIdle, StDiv, StMx, StMz, StSx, StSz, StCvt, StEmit
  } proj_state_t;

endpackage

// File: rtl/float_div.sv
// Fixed-latency single-precision divider a/b, AXI-stream style; truncating, denormals flush to zero.
module float_div #(
  parameter int unsigned LATENCY = 6
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);

  logic [31:0]       a, b, res;
  logic [24:0]       quot;
  logic signed [9:0] exp_q;
  logic              sign;
  logic [LATENCY-1:0] vld;
  logic [31:0]       pipe [LATENCY];

  always_comb begin
    a     = s_axis_a_tdata;
    b     = s_axis_b_tdata;
    sign  = a[31] ^ b[31];
    // mantissa ratio lies in (0.5, 2), so the quotient has 25 or 26 significant bits
    quot  = 25'((49'({1'b1, a[22:0], 25'd0}) / 49'({1'b1, b[22:0]})) >> 1);
    exp_q = 10'(a[30:23]) - 10'(b[30:23]) + (quot[24] ? 10'sd127 : 10'sd126);
    if (a[30:23] == 8'd0 || b[30:23] == 8'hff) begin
      res = {sign, 31'd0};
    end else if (b[30:23] == 8'd0 || a[30:23] == 8'hff || exp_q >= 10'sd255) begin
      res = {sign, 8'hff, 23'd0};
    end else if (exp_q <= 10'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, exp_q[7:0], quot[24] ? quot[23:1] : quot[22:0]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) vld <= '0;
    else          vld <= LATENCY'({vld, s_axis_a_tvalid & s_axis_b_tvalid});
  end

  always_ff @(posedge aclk) begin
    pipe[0] <= res;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign m_axis_result_tvalid = vld[LATENCY-1];
  assign m_axis_result_tdata  = pipe[LATENCY-1];

endmodule

// File: rtl/float_mul.sv
// Fixed-latency single-precision multiplier, AXI-stream style; truncating, denormals flush to zero.
module float_mul #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);

  logic [31:0]       a, b, res;
  logic [47:0]       prod;
  logic [24:0]       prod_hi;
  logic signed [9:0] exp_sum;
  logic              sign;
  logic [LATENCY-1:0] vld;
  logic [31:0]       pipe [LATENCY];

  always_comb begin
    a       = s_axis_a_tdata;
    b       = s_axis_b_tdata;
    sign    = a[31] ^ b[31];
    prod    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    prod_hi = 25'(prod >> 23);
    exp_sum = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127 + (prod_hi[24] ? 10'sd1 : 10'sd0);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      res = {sign, 31'd0};
    end else if (a[30:23] == 8'hff || b[30:23] == 8'hff || exp_sum >= 10'sd255) begin
      res = {sign, 8'hff, 23'd0};
    end else if (exp_sum <= 10'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, exp_sum[7:0], prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0]};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) vld <= '0;
    else          vld <= LATENCY'({vld, s_axis_a_tvalid & s_axis_b_tvalid});
  end

  always_ff @(posedge aclk) begin
    pipe[0] <= res;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign m_axis_result_tvalid = vld[LATENCY-1];
  assign m_axis_result_tdata  = pipe[LATENCY-1];

endmodule

// File: rtl/float_to_int.sv
// Registered float to 12-bit signed integer: truncates toward zero, saturates to +/-2047.
module float_to_int (
  input  logic               clk_in,
  input  logic [31:0]        value,
  output logic signed [11:0] result
);

  logic [7:0]  exp;
  logic [10:0] mag;

  always_comb begin
    exp = value[30:23];
    mag = '0;
    // exp >= 138 means |v| >= 2048; this also covers Inf and NaN
    if (exp >= 8'd138) begin
      mag = 11'd2047;
    end else if (exp >= 8'd127) begin
      mag = 11'({1'b1, value[22:0]} >> (8'd150 - exp));
    end
  end

  always_ff @(posedge clk_in) begin
    result <= value[31] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

// File: rtl/perspective_project.sv
// Perspective divide by depth and mapping to 1280x720 pixels using one shared divider and multiplier.
module perspective_project
  import graphics_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0][31:0] pos,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic [31:0]      depth_out,
  output logic             on_screen_out,
  output logic             valid_out
);

  localparam int DrainW = $clog2(DRAIN_CYCLES);

  proj_state_t        state;
  logic [DrainW-1:0]  drain_cnt;
  logic [31:0]        x_f, y_f, z_f, r_f, mx_f, mz_f, sx_f, sz_f;
  logic               clipped;
  logic               div_tvalid, mul_tvalid;
  logic [31:0]        div_b, mul_a, mul_b;
  logic               div_res_valid, mul_res_valid;
  logic [31:0]        div_res, mul_res;
  logic signed [11:0] ix, iz, ix_sel, iz_sel;
  logic signed [12:0] px, py;
  logic               on_screen;
  logic               unused_w;

  assign unused_w = ^pos[3];

  float_div u_div (
    .aclk                 (clk_in),
    .aresetn              (!rst_in),
    .s_axis_a_tvalid      (div_tvalid),
    .s_axis_a_tdata       (ONE_F),
    .s_axis_b_tvalid      (div_tvalid),
    .s_axis_b_tdata       (div_b),
    .m_axis_result_tvalid (div_res_valid),
    .m_axis_result_tdata  (div_res)
  );

  float_mul u_mul (
    .aclk                 (clk_in),
    .aresetn              (!rst_in),
    .s_axis_a_tvalid      (mul_tvalid),
    .s_axis_a_tdata       (mul_a),
    .s_axis_b_tvalid      (mul_tvalid),
    .s_axis_b_tdata       (mul_b),
    .m_axis_result_tvalid (mul_res_valid),
    .m_axis_result_tdata  (mul_res)
  );

  float_to_int u_cvt_x (.clk_in(clk_in), .value(sx_f), .result(ix));
  float_to_int u_cvt_z (.clk_in(clk_in), .value(sz_f), .result(iz));

  always_comb begin
    // converter outputs are stale on the near-clip path; pin to the screen centre instead
    ix_sel    = clipped ? 12'sd0 : ix;
    iz_sel    = clipped ? 12'sd0 : iz;
    px        = 13'(HALF_W) + {ix_sel[11], ix_sel};
    py        = 13'(HALF_H) - {iz_sel[11], iz_sel};
    on_screen = !clipped && !px[12] && (px < 13'(SCREEN_W)) && !py[12] && (py < 13'(SCREEN_H));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= StDrain;
      drain_cnt     <= '0;
      ready_out     <= 1'b0;
      valid_out     <= 1'b0;
      hcount_out    <= '0;
      vcount_out    <= '0;
      depth_out     <= '0;
      on_screen_out <= 1'b0;
      div_tvalid    <= 1'b0;
      mul_tvalid    <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      div_tvalid <= 1'b0;
      mul_tvalid <= 1'b0;
      unique case (state)
        StDrain: begin
          if (drain_cnt == DrainW'(DRAIN_CYCLES - 1)) begin
            state     <= StIdle;
            ready_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        StIdle: begin
          if (valid_in && ready_out) begin
            x_f       <= pos[0];
            y_f       <= pos[1];
            z_f       <= pos[2];
            ready_out <= 1'b0;
            if (pos[1][31] || pos[1] < NEAR_F) begin
              clipped <= 1'b1;
              state   <= StEmit;
            end else begin
              clipped    <= 1'b0;
              div_b      <= pos[1];
              div_tvalid <= 1'b1;
              state      <= StDiv;
            end
          end
        end
        StDiv: if (div_res_valid) begin
          r_f <= div_res; mul_a <= x_f; mul_b <= div_res; mul_tvalid <= 1'b1; state <= StMx;
        end
        StMx: if (mul_res_valid) begin
          mx_f <= mul_res; mul_a <= z_f; mul_b <= r_f; mul_tvalid <= 1'b1; state <= StMz;
        end
        StMz: if (mul_res_valid) begin
          mz_f <= mul_res; mul_a <= mx_f; mul_b <= SCALE_F; mul_tvalid <= 1'b1; state <= StSx;
        end
        StSx: if (mul_res_valid) begin
          sx_f <= mul_res; mul_a <= mz_f; mul_b <= SCALE_F; mul_tvalid <= 1'b1; state <= StSz;
        end
        StSz: if (mul_res_valid) begin
          sz_f <= mul_res; state <= StCvt;
        end
        StCvt: state <= StEmit;
        StEmit: begin
          hcount_out    <= px[10:0];
          vcount_out    <= py[9:0];
          depth_out     <= y_f;
          on_screen_out <= on_screen;
          valid_out     <= 1'b1;
          ready_out     <= 1'b1;
          state         <= StIdle;
        end
        default: state <= StDrain;
      endcase
    end
  end

endmodule

// File: doc/perspective_project.md
Name: perspective_project

Overview:
- Stage directly downstream of the view transformation. It consumes one transformed homogeneous point per transaction.
- Input: four IEEE-754 single-precision words. [0]=x, [1]=y (depth, already offset by camera distance), [2]=z (up), [3]=w.
- Performs the perspective divide by y and maps the result to 1280x720 integer pixel coordinates, with near-plane and off-screen flagging, for the rasteriser.
- A single shared float divider and a single shared float multiplier are time-multiplexed by an FSM.

Parameters:
- HALF_W, 640, horizontal screen centre in pixels.
- HALF_H, 360, vertical screen centre in pixels; also the projection scale for both axes (square pixels).
- SCALE_F, 32'h43b40000, HALF_H as a float (360.0).
- NEAR_F, 32'h3dcccccd, near-plane depth as a float (0.1).
- DRAIN_CYCLES, 32, cycles ready_out stays low after reset so in-flight IP results are discarded.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- pos  in  32x[3:0]  float point from the transformation stage
- valid_in  in  1  pos valid this cycle
- ready_out  out  1  block can accept a point
- hcount_out  out  11  projected pixel x
- vcount_out  out  10  projected pixel y
- depth_out  out  32  float y, passed through for z-buffering
- on_screen_out  out  1  point is visible and in bounds
- valid_out  out  1  single-cycle pulse; the outputs above are valid

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, on clk_in/rst_in.
- Reset values: valid_out=0, ready_out=0, hcount_out=0, vcount_out=0, depth_out=0, on_screen_out=0, state=DRAIN, drain counter=0.
- Reset mid-operation: the FSM abandons its work and re-enters DRAIN. Late divider or multiplier results are ignored.
- Handshake:
  - A transfer occurs when valid_in && ready_out.
  - ready_out=1 only in IDLE.
  - pos is captured into internal registers on transfer; the upstream may change pos afterwards.
  - valid_in while ready_out=0 is ignored (not queued).
- States:
  - DRAIN: count to DRAIN_CYCLES-1, then go to IDLE.
  - IDLE: on transfer, capture pos.
    - If y is negative (sign bit set) or y_bits < NEAR_F (unsigned compare of positive floats), go to EMIT with on_screen=0.
    - Otherwise issue divider 1.0/y with a one-cycle tvalid pulse and go to DIV.
  - DIV: wait for divider tvalid, then latch r.
  - MX: compute mx = x*r.
  - MZ: compute mz = z*r.
  - SX: compute sx = mx*SCALE_F.
  - SZ: compute sz = mz*SCALE_F.
  - Multiply handshake (MX, MZ, SX, SZ): each state issues a one-cycle multiplier tvalid pulse on entry and waits for multiplier tvalid before advancing.
  - CVT: float_to_int converts sx and sz (one cycle each, or in parallel with two instances).
  - EMIT: drive outputs, pulse valid_out for exactly one cycle, return to IDLE.
- Arithmetic:
  - px = HALF_W + ix; py = HALF_H - iz. Both are computed as 13-bit signed.
  - on_screen = near-clip passed && 0<=px<=1279 && 0<=py<=719.
  - hcount_out = px[10:0]; vcount_out = py[9:0]. These are undefined-but-deterministic truncations when on_screen=0.
  - depth_out = captured y in all cases.
- float_to_int:
  - Truncates toward zero.
  - Saturates to 12-bit signed ±2047.
  - NaN/Inf saturate by sign.
  - Denormals and |v|<1 give 0.
- Latency:
  - Near-clipped point: valid_out exactly 2 cycles after the transfer.
  - Otherwise: div latency + 4×mult latency + a fixed FSM overhead of ≤8 cycles. It must be identical for every non-clipped point.
- Boundary: x=0 and z=0 give exactly px=640, py=360. The w input is ignored.

Decomposition:
- Shared package (graphics_pkg):
  - screen constants (1280, 720, HALF_W, HALF_H)
  - float constants (ONE_F=32'h3f800000, SCALE_F, NEAR_F)
  - FSM state enum
- Sub-module float_to_int: registered, 1-cycle latency, 32-bit float in, 12-bit signed out.
- Existing IP: multiplier IP reused; divider IP with the same AXI-stream port style.

Test Plan:
- Reset, hold valid_in → ready_out=0 for DRAIN_CYCLES, then 1. No valid_out during that time.
- pos={x=3f800000, y=40000000, z=0, w=3f800000} → hcount 820, vcount 360, on_screen 1, depth 40000000.
- pos={x=0, y=40800000, z=3f800000} → hcount 640, vcount 270, on_screen 1.
- pos={x=40800000, y=3f800000, z=0} → px=2080 → on_screen 0, valid_out still pulses once.
- pos y=bf800000 (behind camera) and y=3c23d70a (0.01 < NEAR) → on_screen 0, valid_out 2 cycles after transfer, no IP activity.
- Assert rst_in mid-DIV, then send the 820/360 vector after drain → the correct single result, no stale valid_out.
- Back-to-back valid_in held high → exactly one transfer per IDLE visit; consecutive latencies equal.
